// File: rtl/rs_issue_scheduler.sv
// Issue select for the reservation station: up to NUM_ALU ALU ops plus one load/store op per cycle,
// rotating priority, registered grants and slot-clear vector. Optional counters under ISSUE_STATS_EN.
module rs_issue_scheduler #(
  parameter int RS_SIZE = 64,
  parameter int IDX_W   = 6,
  parameter int NUM_ALU = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [RS_SIZE-1:0]       req_ready,
  input  logic [RS_SIZE-1:0]       req_is_ls,
  input  logic [NUM_ALU-1:0]       fu_ready,
  input  logic                     lsu_ready,
  output logic [NUM_ALU-1:0]       alu_issue_valid,
  output logic [NUM_ALU*IDX_W-1:0] alu_issue_idx,
  output logic                     ls_issue_valid,
  output logic [IDX_W-1:0]         ls_issue_idx,
  output logic [RS_SIZE-1:0]       clear_vec
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_stall
`endif
);

  logic [IDX_W-1:0]         alu_ptr;
  logic [IDX_W-1:0]         ls_ptr;
  logic [RS_SIZE-1:0]       alu_cand;
  logic [RS_SIZE-1:0]       ls_cand;

  logic [NUM_ALU-1:0]       sel_valid;
  logic [NUM_ALU*IDX_W-1:0] sel_idx;
  logic [RS_SIZE-1:0]       sel_alu_clear;
  logic [IDX_W-1:0]         sel_alu_ptr;
  logic [NUM_ALU-1:0]       fu_used;
  logic [IDX_W-1:0]         slot;
  logic                     placed;

  logic                     sel_ls_valid;
  logic [IDX_W-1:0]         sel_ls_idx;
  logic [RS_SIZE-1:0]       sel_ls_clear;
  logic [IDX_W-1:0]         ls_slot;
  logic [RS_SIZE-1:0]       sel_clear;

  // Slots granted last cycle are still visible in req_ready until the RS drops them.
  assign alu_cand  = req_ready & ~req_is_ls & ~clear_vec;
  assign ls_cand   = req_ready &  req_is_ls & ~clear_vec;
  assign sel_clear = sel_alu_clear | sel_ls_clear;

  always_comb begin : alu_select
    sel_valid     = '0;
    sel_idx       = '0;
    sel_alu_clear = '0;
    sel_alu_ptr   = alu_ptr;
    fu_used       = '0;
    slot          = '0;
    placed        = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      slot   = alu_ptr + IDX_W'(i);
      placed = 1'b0;
      if (alu_cand[slot]) begin
        for (int k = 0; k < NUM_ALU; k++) begin
          if (!placed && fu_ready[k] && !fu_used[k]) begin
            placed                     = 1'b1;
            fu_used[k]                 = 1'b1;
            sel_valid[k]               = 1'b1;
            sel_idx[k*IDX_W +: IDX_W]  = slot;
            sel_alu_clear[slot]        = 1'b1;
            sel_alu_ptr                = slot + IDX_W'(1);
          end
        end
      end
    end
  end

  always_comb begin : ls_select
    sel_ls_valid = 1'b0;
    sel_ls_idx   = '0;
    sel_ls_clear = '0;
    ls_slot      = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ls_slot = ls_ptr + IDX_W'(i);
      if (lsu_ready && !sel_ls_valid && ls_cand[ls_slot]) begin
        sel_ls_valid          = 1'b1;
        sel_ls_idx            = ls_slot;
        sel_ls_clear[ls_slot] = 1'b1;
      end
    end
  end

  // ---- select -> registered issue stage ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      alu_issue_valid <= '0;
      alu_issue_idx   <= '0;
      ls_issue_valid  <= 1'b0;
      ls_issue_idx    <= '0;
      clear_vec       <= '0;
      alu_ptr         <= '0;
      ls_ptr          <= '0;
    end else begin
      alu_issue_valid <= sel_valid;
      alu_issue_idx   <= sel_idx;
      ls_issue_valid  <= sel_ls_valid;
      ls_issue_idx    <= sel_ls_idx;
      clear_vec       <= sel_clear;
      alu_ptr         <= sel_alu_ptr;
      if (sel_ls_valid) ls_ptr <= sel_ls_idx + IDX_W'(1);
    end
  end

`ifdef ISSUE_STATS_EN
  logic any_cand;
  logic any_grant;
  assign any_cand  = |{alu_cand, ls_cand};
  assign any_grant = |{sel_valid, sel_ls_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else if (!flush) begin
      stat_issued <= stat_issued + 32'($countones(sel_valid)) + 32'(sel_ls_valid);
      if (any_cand && !any_grant) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
